// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: multi-cycle FP16 add/subtract sequencer, one datapath stage per clock.
// Define FPU_ADDSUB_OPCNT_EN to add the saturating completed-operation counter (opCount).
//
// state | meaning
// IDLE  | waiting for a request
// SORT  | pick the larger-magnitude operand
// ALIGN | shift the smaller significand to the larger exponent
// ADD   | significand add or subtract
// NORM  | normalize, detect overflow, pack the result
// DONE  | result presented until the consumer takes it
module fpu_addsub_seq #(
  parameter int OPCNT_W = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inValid,
  output logic        inReady,
  input  logic        opSub,
  input  logic [15:0] fpuIn1,
  input  logic [15:0] fpuIn2,
  output logic        outValid,
  input  logic        outReady,
  output logic [15:0] fpuOut,
  output logic        overflow
`ifdef FPU_ADDSUB_OPCNT_EN
  ,
  output logic [OPCNT_W-1:0] opCount
`endif
);

  typedef enum logic [2:0] {IDLE, SORT, ALIGN, ADD, NORM, DONE} state_t;

  state_t      state, nextState;
  logic        accept;
  logic [15:0] opA, opB, largeNum, smallNum;
  logic [10:0] sigL, sigS, alignedSmall;
  logic [4:0]  expDiff;
  logic [11:0] sumReg, sumNext;
  logic [15:0] resultReg, normOut;
  logic        ovfReg, normOvf;
  logic [3:0]  lzc;
  logic [5:0]  expWide, expInc, normShift, expDec;
  logic [9:0]  fracShl;

  if (OPCNT_W < 1) begin : gOpcntWCheck
    $error("OPCNT_W must be at least 1");
  end

  assign inReady  = (state == IDLE) || (state == DONE && outReady);
  assign outValid = (state == DONE);
  assign accept   = inValid && inReady;
  assign fpuOut   = resultReg;
  assign overflow = ovfReg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = SORT;
      SORT:    nextState = ALIGN;
      ALIGN:   nextState = ADD;
      ADD:     nextState = NORM;
      NORM:    nextState = DONE;
      DONE:    if (outReady) nextState = inValid ? SORT : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Bits shifted past the LSB are dropped; a shift of 11+ leaves zero.
  assign expDiff      = largeNum[14:10] - smallNum[14:10];
  assign alignedSmall = {|smallNum[14:10], smallNum[9:0]} >> expDiff;
  assign sumNext      = (largeNum[15] == smallNum[15]) ? ({1'b0, sigL} + {1'b0, sigS})
                                                       : ({1'b0, sigL} - {1'b0, sigS});

  always_comb begin
    lzc = 4'd10;
    for (int i = 0; i < 10; i++)
      if (sumReg[i]) lzc = 4'(9 - i);
  end

  assign expWide   = {1'b0, largeNum[14:10]};
  assign expInc    = expWide + 6'd1;
  assign normShift = {2'b00, lzc} + 6'd1;
  assign expDec    = expWide - normShift;
  assign fracShl   = sumReg[9:0] << normShift;

  always_comb begin
    normOut = 16'h0000;
    normOvf = 1'b0;
    if (sumReg[11]) begin
      // Exponent 31 inputs (Inf/NaN treated as finite) also land here.
      if (expInc >= 6'd31) begin
        normOut = {largeNum[15], 5'h1F, 10'h000};
        normOvf = 1'b1;
      end else begin
        normOut = {largeNum[15], expInc[4:0], sumReg[10:1]};
      end
    end else if (sumReg[10]) begin
      normOut = {largeNum[15], largeNum[14:10], sumReg[9:0]};
    end else if (sumReg[9:0] != 10'd0) begin
      if (expWide > normShift) normOut = {largeNum[15], expDec[4:0], fracShl};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opA       <= '0;
      opB       <= '0;
      largeNum  <= '0;
      smallNum  <= '0;
      sigL      <= '0;
      sigS      <= '0;
      sumReg    <= '0;
      resultReg <= '0;
      ovfReg    <= 1'b0;
    end else begin
      if (accept) begin
        opA <= fpuIn1;
        opB <= {fpuIn2[15] ^ opSub, fpuIn2[14:0]};
      end
      case (state)
        SORT: begin
          // Equal magnitudes pick the second operand as the larger one.
          if (opA[14:0] > opB[14:0]) begin
            largeNum <= opA;
            smallNum <= opB;
          end else begin
            largeNum <= opB;
            smallNum <= opA;
          end
        end
        ALIGN: begin
          sigL <= {|largeNum[14:10], largeNum[9:0]};
          sigS <= alignedSmall;
        end
        ADD:  sumReg <= sumNext;
        NORM: begin
          resultReg <= normOut;
          ovfReg    <= normOvf;
        end
        default: ;
      endcase
    end
  end

`ifdef FPU_ADDSUB_OPCNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      opCount <= '0;
    else if (outValid && outReady && (opCount != {OPCNT_W{1'b1}}))
      opCount <= opCount + OPCNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb_fpu_addsub_seq: scoreboard bench for fpu_addsub_seq with a numeric reference model.
// Define FPU_ADDSUB_OPCNT_EN to also exercise opCount.
module tb_fpu_addsub_seq;
  localparam int OPCNT_W = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        opSub = 1'b0;
  logic [15:0] fpuIn1 = 16'h0;
  logic [15:0] fpuIn2 = 16'h0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [15:0] fpuOut;
  logic        overflow;
`ifdef FPU_ADDSUB_OPCNT_EN
  logic [OPCNT_W-1:0] opCount;
`endif

  int          total = 0;
  int          bad = 0;
  logic [16:0] expQ[$];
  bit          randReady = 1'b0;

  fpu_addsub_seq #(.OPCNT_W(OPCNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .inValid(inValid), .inReady(inReady),
    .opSub(opSub), .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .outValid(outValid),
    .outReady(outReady), .fpuOut(fpuOut), .overflow(overflow)
`ifdef FPU_ADDSUB_OPCNT_EN
    , .opCount(opCount)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
    end
  endtask

  // Value-level model: significands as integers, normalization as a loop.
  function automatic logic [16:0] refAdd(input logic [15:0] a, input logic [15:0] bIn, input logic s);
    logic [15:0] b, big, sml;
    int eL, eS, sL, sS, tot;
    bit shifted;
    b = bIn;
    if (s) b[15] = ~b[15];
    if (a[14:0] > b[14:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    eL = int'(big[14:10]);
    eS = int'(sml[14:10]);
    sL = (eL != 0 ? 1024 : 0) + int'(big[9:0]);
    sS = ((eS != 0 ? 1024 : 0) + int'(sml[9:0])) >> (eL - eS);
    tot = (big[15] == sml[15]) ? sL + sS : sL - sS;
    if (tot == 0) return 17'h0;
    shifted = 1'b0;
    if (tot >= 2048) begin
      tot = tot / 2;
      eL = eL + 1;
      if (eL >= 31) return {1'b1, big[15], 5'h1F, 10'h0};
    end else begin
      while (tot < 1024) begin
        tot = tot * 2;
        eL = eL - 1;
        shifted = 1'b1;
      end
      if (shifted && eL <= 0) return 17'h0;
    end
    return {1'b0, big[15], 5'(eL), 10'(tot)};
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [16:0] want);
    int n = 0;
    @(posedge clock); #1;
    inValid = 1'b1; fpuIn1 = a; fpuIn2 = b; opSub = s;
    forever begin
      @(negedge clock);
      if (inReady) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'd1, 32'd0);
        inValid = 1'b0;
        return;
      end
    end
    @(posedge clock);
    expQ.push_back(want);
    #1;
    inValid = 1'b0;
    fpuIn1 = 16'($urandom);
    fpuIn2 = 16'($urandom);
    opSub = 1'($urandom);
  endtask

  task automatic waitLatency(input int want);
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!outValid && k < 20);
    check("latency", 32'(k), 32'(want));
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("drain_empty", 32'(expQ.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  // Monitor: every accepted result is popped and compared.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clock);
      if (reset_n && outValid && outReady) begin
        if (expQ.size() == 0) check("unexpected_result", 32'(fpuOut), 32'hFFFF_FFFF);
        else begin
          e = expQ.pop_front();
          check("fpuOut", 32'(fpuOut), 32'(e[15:0]));
          check("overflow", 32'(overflow), 32'(e[16]));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock); #1;
      if (randReady) outReady = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [15:0] dA[8] = '{16'h4200, 16'h3C00, 16'h7BFF, 16'hFBFF, 16'h7000, 16'h0401, 16'h3C01, 16'h3C00};
  logic [15:0] dB[8] = '{16'h3C00, 16'h3C00, 16'h7BFF, 16'hFBFF, 16'h3C00, 16'h0400, 16'h3C00, 16'hC000};
  logic        dS[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [16:0] dE[8] = '{17'h04000, 17'h00000, 17'h17C00, 17'h1FC00, 17'h07000, 17'h00000, 17'h01400, 17'h0BC00};

  initial begin
    int n;
    logic [15:0] a, b;
    logic s;

    #3 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_outValid", 32'(outValid), 32'd0);
    check("rst_inReady", 32'(inReady), 32'd1);
    check("rst_fpuOut", 32'(fpuOut), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
`ifdef FPU_ADDSUB_OPCNT_EN
    check("rst_opCount", 32'(opCount), 32'd0);
`endif
    @(negedge clock) reset_n = 1'b1;

    // First operation: latency counted in cycles from the accepting edge.
    outReady = 1'b1;
    issue(16'h3C00, 16'h4000, 1'b0, 17'h04200);
    waitLatency(5);
    drain();

    for (int i = 0; i < 8; i++) begin
      issue(dA[i], dB[i], dS[i], dE[i]);
      drain();
    end

    // Consumer stalls in DONE, then takes the result while a new request lands.
    outReady = 1'b0;
    issue(16'h4000, 16'h3C00, 1'b0, 17'h04200);
    n = 0;
    do begin @(negedge clock); n++; end while (!outValid && n < 20);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      check("hold_outValid", 32'(outValid), 32'd1);
      check("hold_fpuOut", 32'(fpuOut), 32'h4200);
      check("hold_inReady", 32'(inReady), 32'd0);
    end
    @(posedge clock); #1;
    outReady = 1'b1;
    inValid = 1'b1; fpuIn1 = 16'h3E00; fpuIn2 = 16'h3E00; opSub = 1'b0;
    @(negedge clock);
    check("b2b_inReady", 32'(inReady), 32'd1);
    @(posedge clock);
    expQ.push_back(17'h04200);
    #1 inValid = 1'b0;
    waitLatency(5);
    drain();

    // Reset while the operation is in ALIGN.
    issue(16'h3C00, 16'h4000, 1'b0, 17'h04200);
    @(posedge clock); #1;
    check("busy_inReady", 32'(inReady), 32'd0);
    reset_n = 1'b0;
    #1;
    check("midrst_outValid", 32'(outValid), 32'd0);
    check("midrst_inReady", 32'(inReady), 32'd1);
    check("midrst_fpuOut", 32'(fpuOut), 32'd0);
    expQ.delete();
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clock);
      if (outValid) n++;
    end
    check("no_result_after_reset", 32'(n), 32'd0);

`ifdef FPU_ADDSUB_OPCNT_EN
    check("cnt_after_reset", 32'(opCount), 32'd0);
    issue(16'h3C00, 16'h3C00, 1'b0, refAdd(16'h3C00, 16'h3C00, 1'b0));
    issue(16'h4400, 16'h3C00, 1'b1, refAdd(16'h4400, 16'h3C00, 1'b1));
    check("cnt_one", 32'(opCount), 32'd1);
    issue(16'h5000, 16'hC800, 1'b0, refAdd(16'h5000, 16'hC800, 1'b0));
    check("cnt_two", 32'(opCount), 32'd2);
    drain();
    check("cnt_three", 32'(opCount), 32'd3);
`endif

    // Randomized operands with a randomly stalling consumer.
    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = {b[15], a[14:10], b[9:0]};
        2: b = {b[15], 5'(a[14:10] - 5'($urandom_range(0, 12))), b[9:0]};
        default: ;
      endcase
      issue(a, b, s, refAdd(a, b, s));
    end
    drain();
    randReady = 1'b0;
    @(posedge clock); #1 outReady = 1'b1;
    repeat (3) @(posedge clock);
    check("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
